mem_responder: RTL and testbench

Main-memory responder for the data-cache memory port. It is the memory-side end of the cache request/receive protocol. It accepts cacheline read and write-back requests from the data cache and stores lines in an internal array. Reads are served one at a time, with a fixed per-read latency, in arrival order. Each completed read is returned as a one-cycle receive pulse carrying the line address and cacheline.

---
 rtl/mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the data-cache request/receive port.
// Stores cachelines in an internal array. Write-backs are posted, with no
// response. Reads queue in a small FIFO and are served one at a time by a
// bank FSM. Each read holds the bank for LATENCY cycles, and then a
// one-cycle receive pulse returns the line.
//
// Handshake: the request side has no back-pressure. A read or write is
// taken on any edge where its enable is high. A read that finds DEPTH reads
// outstanding, on an edge with no completion, is dropped and sets the
// sticky overflow flag. The receive side is a bare one-cycle valid
// (mem_rec_en). The consumer must take it in that cycle.
module mem_responder #(
  parameter int LATENCY   = 5,
  parameter int DEPTH     = 4,
  parameter int MEM_LINES = 4096,
  parameter int PADDR_W   = 32,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_req_ren,
  input  logic [PADDR_W-1:0]   mem_req_raddr,
  input  logic                 mem_req_wen,
  input  logic [PADDR_W-1:0]   mem_req_waddr,
  input  logic [LINE_BITS-1:0] mem_req_wcacheline,
  output logic                 mem_rec_en,
  output logic [PADDR_W-1:0]   mem_rec_addr,
  output logic [LINE_BITS-1:0] mem_rec_cacheline,
  output logic                 busy,
  output logic                 overflow
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int LINE_W = PADDR_W - 4;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int OCNT_W = FCNT_W + 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0]  LAT_C    = CNT_W'(LATENCY);
  localparam logic [OCNT_W-1:0] DEPTH_C  = OCNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   svc_line_q, svc_line_d;
  logic [LINE_W-1:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [LINE_BITS-1:0] mem_q [MEM_LINES];

  logic                 rec_en_q;
  logic [PADDR_W-1:0]   rec_addr_q;
  logic [LINE_BITS-1:0] rec_line_q;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  logic              completing;
  logic              bank_free;
  logic              accept;
  logic              pop;
  logic              bypass;
  logic              push;
  logic              fwd_hit;
  logic [OCNT_W-1:0] outstanding;

  // Offset bits and aliased upper write-address bits take no part in indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_raddr[3:0], mem_req_waddr[3:0],
                              mem_req_waddr[PADDR_W-1:4+IDX_W]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Bank FSM next state, queue bookkeeping and acceptance of incoming reads.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    svc_line_d = svc_line_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    completing  = (state_q == ST_SERVE) && (cnt_q == CNT_W'(1));
    outstanding = OCNT_W'(fcnt_q) + OCNT_W'(state_q == ST_SERVE);
    bank_free   = (state_q == ST_IDLE) || completing;
    // A completion on this edge frees the slot the new read needs.
    accept      = mem_req_ren && ((outstanding < DEPTH_C) || completing);
    pop         = bank_free && (fcnt_q != '0);
    bypass      = bank_free && (fcnt_q == '0) && accept;
    push        = accept && !bypass;

    if (mem_req_ren && !accept) overflow_d = 1'b1;

    if (state_q == ST_SERVE) cnt_d = cnt_q - 1'b1;
    if (completing) state_d = ST_IDLE;

    if (pop) begin
      svc_line_d = fifo_q[rd_ptr_q];
      rd_ptr_d   = ptr_inc(rd_ptr_q);
    end else if (bypass) begin
      svc_line_d = mem_req_raddr[PADDR_W-1:4];
    end

    // Back-to-back service: the next read starts on the completing edge.
    if (pop || bypass) begin
      state_d = ST_SERVE;
      cnt_d   = LAT_C;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);

    busy_d = (fcnt_d != '0) || (state_d == ST_SERVE);

    // Write-first: a write to the served line on the completing edge wins.
    fwd_hit = mem_req_wen &&
              (mem_req_waddr[4 +: IDX_W] == svc_line_q[IDX_W-1:0]);
  end

  // Control state: FSM, latency counter, FIFO pointers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      svc_line_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      svc_line_q <= svc_line_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Receive registers are loaded only on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_en_q   <= 1'b0;
      rec_addr_q <= '0;
      rec_line_q <= '0;
    end else begin
      rec_en_q <= completing;
      if (completing) begin
        rec_addr_q <= {svc_line_q, 4'b0000};
        rec_line_q <= fwd_hit ? mem_req_wcacheline
                              : mem_q[svc_line_q[IDX_W-1:0]];
      end
    end
  end

  // FIFO payload storage. Occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_req_raddr[PADDR_W-1:4];
  end

  // Line array. Not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_req_wen) mem_q[mem_req_waddr[4 +: IDX_W]] <= mem_req_wcacheline;
  end

  assign mem_rec_en        = rec_en_q;
  assign mem_rec_addr      = rec_addr_q;
  assign mem_rec_cacheline = rec_line_q;
  assign busy              = busy_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY=5 and DEPTH=4.
// An edge counter timestamps every receive pulse. Each scenario queues the
// expected (edge, address, line) triples, and the log is compared against them.
module tb_mem_responder;

  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req_ren = 1'b0;
  logic [31:0]  mem_req_raddr = '0;
  logic         mem_req_wen = 1'b0;
  logic [31:0]  mem_req_waddr = '0;
  logic [127:0] mem_req_wcacheline = '0;
  logic         mem_rec_en;
  logic [31:0]  mem_rec_addr;
  logic [127:0] mem_rec_cacheline;
  logic         busy;
  logic         overflow;

  mem_responder #(.LATENCY(L), .DEPTH(4), .MEM_LINES(4096)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_req_ren        (mem_req_ren),
    .mem_req_raddr      (mem_req_raddr),
    .mem_req_wen        (mem_req_wen),
    .mem_req_waddr      (mem_req_waddr),
    .mem_req_wcacheline (mem_req_wcacheline),
    .mem_rec_en         (mem_rec_en),
    .mem_rec_addr       (mem_rec_addr),
    .mem_rec_cacheline  (mem_rec_cacheline),
    .busy               (busy),
    .overflow           (overflow)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- response log / expected queues ----------------
  int            rsp_cyc[$];
  logic [31:0]   rsp_addr[$];
  logic [127:0]  rsp_data[$];
  int            exp_cyc_q[$];
  logic [31:0]   exp_addr_q[$];
  logic [127:0]  exp_data_q[$];

  always @(negedge clk) begin
    if (mem_rec_en) begin
      rsp_cyc.push_back(cyc);
      rsp_addr.push_back(mem_rec_addr);
      rsp_data.push_back(mem_rec_cacheline);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic expect_rsp(input int c, input logic [31:0] a, input logic [127:0] d);
    exp_cyc_q.push_back(c);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 128'(rsp_cyc.size()), 128'(exp_cyc_q.size()));
    for (int i = 0; i < exp_cyc_q.size() && i < rsp_cyc.size(); i++) begin
      check($sformatf("%s_%0d_edge", tag, i), 128'(rsp_cyc[i]), 128'(exp_cyc_q[i]));
      check($sformatf("%s_%0d_addr", tag, i), 128'(rsp_addr[i]), 128'(exp_addr_q[i]));
      check($sformatf("%s_%0d_data", tag, i), rsp_data[i], exp_data_q[i]);
    end
    rsp_cyc.delete(); rsp_addr.delete(); rsp_data.delete();
    exp_cyc_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d);
    mem_req_wen = 1'b1; mem_req_waddr = a; mem_req_wcacheline = d;
    tick();
    mem_req_wen = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    mem_req_ren = 1'b1; mem_req_raddr = a;
    tick();
    mem_req_ren = 1'b0;
  endtask

  task automatic do_rw(input logic [31:0] ra, input logic [31:0] wa, input logic [127:0] d);
    mem_req_ren = 1'b1; mem_req_raddr = ra;
    mem_req_wen = 1'b1; mem_req_waddr = wa; mem_req_wcacheline = d;
    tick();
    mem_req_ren = 1'b0; mem_req_wen = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [127:0] pat(input int k);
    return {4{32'(k * 3 + 1)}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    logic [127:0] line_a, line_dead, line_old, line_g, line_rw;
    line_a    = {16{8'hA5}};
    line_dead = {8{16'hDEAD}};
    line_old  = {4{32'h0123_4567}};
    line_g    = {4{32'h5A5A_0F0F}};
    line_rw   = {4{32'hC0FF_EE00}};

    // Reset values while reset is held.
    #1;
    check("rst_rec_en", 128'(mem_rec_en), 128'(0));
    check("rst_rec_addr", 128'(mem_rec_addr), 128'(0));
    check("rst_rec_data", mem_rec_cacheline, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    idle(2);
    rst = 1'b0;
    idle(2);

    // Write then read: write 0x40 at E0, read 0x48 at E1, pulse after E6.
    do_write(32'h40, line_a);
    e0 = cyc;
    do_read(32'h48);
    check("a_busy", 128'(busy), 128'(1));
    expect_rsp(e0 + 6, 32'h40, line_a);
    idle(12);
    check_log("wr_rd");

    // Same-edge forwarding: read 0x100 at E0, write DEAD at E5.
    do_write(32'h100, line_old);
    do_read(32'h100);
    e0 = cyc;
    idle(4);
    do_write(32'h100, line_dead);
    expect_rsp(e0 + L, 32'h100, line_dead);
    idle(8);
    check_log("fwd");

    // Burst of four reads to preloaded lines 1..4.
    for (int k = 1; k <= 4; k++) do_write(32'(k * 16), pat(k));
    for (int k = 0; k < 4; k++) begin
      do_read(32'((k + 1) * 16));
      if (k == 0) e0 = cyc;
      expect_rsp(e0 + L * (k + 1), 32'((k + 1) * 16), pat(k + 1));
    end
    wait_until(e0 + 19);
    check("burst_busy_e19", 128'(busy), 128'(1));
    tick();
    check("burst_busy_e20", 128'(busy), 128'(0));
    check("burst_overflow", 128'(overflow), 128'(0));
    idle(3);
    check_log("burst");

    // Overflow: five reads on E0..E4, the fifth is dropped.
    for (int k = 0; k < 5; k++) begin
      do_read(32'((k + 1) * 16));
      if (k == 0) e0 = cyc;
      if (k < 4) expect_rsp(e0 + L * (k + 1), 32'((k + 1) * 16), pat(k + 1));
      if (k == 3) check("ovf_before", 128'(overflow), 128'(0));
    end
    check("ovf_set", 128'(overflow), 128'(1));
    idle(25);
    check("ovf_sticky", 128'(overflow), 128'(1));
    check_log("ovf");

    // Asynchronous reset mid-cycle while a response pulse is showing.
    for (int k = 0; k < 5; k++) begin
      do_read(32'((k + 1) * 16));
      if (k == 0) e0 = cyc;
    end
    wait_until(e0 + L);
    check("pre_rst_rec_en", 128'(mem_rec_en), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rec_en", 128'(mem_rec_en), 128'(0));
    check("mid_rst_rec_addr", 128'(mem_rec_addr), 128'(0));
    check("mid_rst_rec_data", mem_rec_cacheline, 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_overflow", 128'(overflow), 128'(0));
    idle(2);
    rst = 1'b0;
    idle(20);
    check_log("post_rst_quiet");
    do_read(32'h30);
    e0 = cyc;
    expect_rsp(e0 + L, 32'h30, pat(3));
    idle(8);
    check_log("post_rst_read");

    // Completion edge frees a slot: fifth read at E5 is accepted.
    for (int k = 0; k < 4; k++) begin
      do_read(32'((k + 1) * 16));
      if (k == 0) e0 = cyc;
      expect_rsp(e0 + L * (k + 1), 32'((k + 1) * 16), pat(k + 1));
    end
    idle(1);
    do_read(32'h20);
    expect_rsp(e0 + 25, 32'h20, pat(2));
    wait_until(e0 + 28);
    check("slot_overflow", 128'(overflow), 128'(0));
    check_log("slot_free");

    // Upper address bits alias onto the same line index.
    do_write(32'h10, line_g);
    do_read(32'h0001_0018);
    e0 = cyc;
    expect_rsp(e0 + L, 32'h0001_0010, line_g);
    idle(8);
    check_log("alias");

    // Read and write in the same cycle: both honoured.
    do_rw(32'h60, 32'h60, line_rw);
    e0 = cyc;
    expect_rsp(e0 + L, 32'h60, line_rw);
    idle(8);
    check_log("rw_same");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
